// File: rtl/ibex_pext_mac_seq.sv
// ============================================================================
//  Module   : ibex_pext_mac_seq
//  Purpose  : Multi-cycle sequencer for the P-extension 32x32 multiply and
//             multiply-accumulate ops (MUL low, KMMAC, KMMSB, MSUBR32).
//             One shared external 17x17 signed multiplier is time-shared over
//             four partial-product cycles into a 64-bit accumulator. The FIN
//             cycle adds/subtracts the addend, saturates where needed, and
//             strobes valid_o for one cycle.
//  Ports    : clk_i, rst_ni        clock, asynchronous active-low reset
//             en_i, flush_i        op request (held until valid_o), kill
//             op_i                 00 MUL, 01 KMMAC, 10 KMMSB, 11 MSUBR32
//             op_a_i/op_b_i/op_c_i multiplicand, multiplier, addend
//             mult_op_a_o/_b_o     17-bit signed operands to the multiplier
//             mult_res_i           34-bit combinational product from it
//             busy_o               high in PP1..FIN
//             valid_o, result_o,   one-cycle result strobe, result and
//             ov_o                 saturation flag (zero when not valid)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_pext_mac_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] op_c_i,
    output logic [16:0] mult_op_a_o,
    output logic [16:0] mult_op_b_o,
    input  logic [33:0] mult_res_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        ov_o
);

    localparam logic [1:0] c_OP_MUL     = 2'b00;
    localparam logic [1:0] c_OP_KMMAC   = 2'b01;
    localparam logic [1:0] c_OP_KMMSB   = 2'b10;
    localparam logic [1:0] c_OP_MSUBR32 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP1  = 3'd1,
        S_PP2  = 3'd2,
        S_PP3  = 3'd3,
        S_FIN  = 3'd4
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [63:0] r_acc;
    logic [63:0] w_acc_nxt;

    // Low halves are unsigned magnitudes, high halves carry the sign, so
    // a = AH*2^16 + AL and the four cross products sum to the exact product.
    logic [16:0] w_al;
    logic [16:0] w_ah;
    logic [16:0] w_bl;
    logic [16:0] w_bh;
    logic [63:0] w_res_sext;

    assign w_al       = {1'b0, op_a_i[15:0]};
    assign w_ah       = {op_a_i[31], op_a_i[31:16]};
    assign w_bl       = {1'b0, op_b_i[15:0]};
    assign w_bh       = {op_b_i[31], op_b_i[31:16]};
    assign w_res_sext = {{30{mult_res_i[33]}}, mult_res_i};

    // ------------------------------------------------------------------
    // State and accumulator registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, accumulator update and multiplier operand steering
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        mult_op_a_o = '0;
        mult_op_b_o = '0;

        case (r_state)
            S_IDLE: begin
                mult_op_a_o = w_al;
                mult_op_b_o = w_bl;
                if (en_i && !flush_i) begin
                    w_acc_nxt   = w_res_sext;
                    w_state_nxt = S_PP1;
                end
            end
            S_PP1: begin
                mult_op_a_o = w_al;
                mult_op_b_o = w_bh;
                if (flush_i || !en_i) begin
                    w_acc_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt   = r_acc + (w_res_sext << 16);
                    w_state_nxt = S_PP2;
                end
            end
            S_PP2: begin
                mult_op_a_o = w_ah;
                mult_op_b_o = w_bl;
                if (flush_i || !en_i) begin
                    w_acc_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt   = r_acc + (w_res_sext << 16);
                    w_state_nxt = S_PP3;
                end
            end
            S_PP3: begin
                mult_op_a_o = w_ah;
                mult_op_b_o = w_bh;
                if (flush_i || !en_i) begin
                    w_acc_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt   = r_acc + (w_res_sext << 32);
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_acc_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Final computation from the exact 64-bit product in r_acc
    // ------------------------------------------------------------------
    logic [31:0] w_p_hi;
    logic [31:0] w_p_lo;
    logic [32:0] w_sum33;
    logic [32:0] w_dif33;
    logic [32:0] w_sat_in;
    logic [31:0] w_fin_res;
    logic        w_fin_ov;
    logic        w_valid;

    assign w_p_hi   = r_acc[63:32];
    assign w_p_lo   = r_acc[31:0];
    assign w_sum33  = {op_c_i[31], op_c_i} + {w_p_hi[31], w_p_hi};
    assign w_dif33  = {op_c_i[31], op_c_i} - {w_p_hi[31], w_p_hi};
    assign w_sat_in = (op_i == c_OP_KMMSB) ? w_dif33 : w_sum33;

    always_comb begin
        w_fin_res = '0;
        w_fin_ov  = 1'b0;
        case (op_i)
            c_OP_MUL: begin
                w_fin_res = w_p_lo;
            end
            c_OP_KMMAC, c_OP_KMMSB: begin
                // The 33-bit sum overflowed the 32-bit range when its two top
                // bits disagree; bit 32 then tells the true sign.
                if (w_sat_in[32] != w_sat_in[31]) begin
                    w_fin_res = w_sat_in[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    w_fin_ov  = 1'b1;
                end else begin
                    w_fin_res = w_sat_in[31:0];
                end
            end
            c_OP_MSUBR32: begin
                w_fin_res = op_c_i - w_p_lo;
            end
            default: begin
                w_fin_res = '0;
            end
        endcase
    end

    assign w_valid  = (r_state == S_FIN) && !flush_i;
    assign valid_o  = w_valid;
    assign busy_o   = (r_state != S_IDLE);
    // Gated so result and flag read as zero outside the strobe, including reset.
    assign result_o = w_valid ? w_fin_res : 32'h0;
    assign ov_o     = w_valid ? w_fin_ov : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_ibex_pext_mac_seq.sv
// ============================================================================
//  Module   : tb_ibex_pext_mac_seq
//  Purpose  : Self-checking bench for ibex_pext_mac_seq. Models the shared
//             17x17 multiplier, predicts results from a full 64-bit product
//             into a scoreboard queue, and compares when valid_o strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_pext_mac_seq;

    localparam logic [1:0] c_OP_MUL     = 2'b00;
    localparam logic [1:0] c_OP_KMMAC   = 2'b01;
    localparam logic [1:0] c_OP_KMMSB   = 2'b10;
    localparam logic [1:0] c_OP_MSUBR32 = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [16:0] mop_a;
    logic [16:0] mop_b;
    logic [33:0] mres;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic        ov;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb_q[$];   // {ov, result}

    // External shared multiplier
    assign mres = 34'($signed(mop_a)) * 34'($signed(mop_b));

    ibex_pext_mac_seq dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .flush_i     (flush),
        .op_i        (op),
        .op_a_i      (a),
        .op_b_i      (b),
        .op_c_i      (c),
        .mult_op_a_o (mop_a),
        .mult_op_b_o (mop_b),
        .mult_res_i  (mres),
        .busy_o      (busy),
        .valid_o     (valid),
        .result_o    (result),
        .ov_o        (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact signed product, then the per-op final step.
    function automatic logic [32:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb, input logic [31:0] mc);
        logic signed [63:0] p;
        logic signed [32:0] s;
        logic        [31:0] hi;
        logic        [31:0] lo;
        p  = 64'($signed(ma)) * 64'($signed(mb));
        hi = p[63:32];
        lo = p[31:0];
        if (mop == c_OP_MUL) return {1'b0, lo};
        if (mop == c_OP_MSUBR32) return {1'b0, mc - lo};
        if (mop == c_OP_KMMAC)
            s = 33'($signed(mc)) + 33'($signed(hi));
        else
            s = 33'($signed(mc)) - 33'($signed(hi));
        if (s > 33'sh0_7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
        if (s < -33'sh0_8000_0000) return {1'b1, 32'h8000_0000};
        return {1'b0, s[31:0]};
    endfunction

    // Drive an op request and record its prediction.
    task automatic issue(input logic [1:0] iop, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] ic);
        op = iop; a = ia; b = ib; c = ic; en = 1'b1;
        sb_q.push_back(model(iop, ia, ib, ic));
    endtask

    // Wait (bounded) for valid_o, sampling on negedges; returns at that negedge.
    task automatic wait_valid(output bit got, output int lat);
        got = 1'b0;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; op = c_OP_MUL;
        a = 32'h1234_ABCD; b = 32'h8765_4321; c = 32'h0;
        #12;
        n_checks++;
        if ({busy, valid, ov, result} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b valid=%b ov=%b result=%h, required all zero",
                     busy, valid, ov, result);
        end
        n_checks++;
        if (mop_a !== 17'h0ABCD || mop_b !== 17'h04321) begin
            n_fail++;
            $display("FAIL reset_mult_ops: a=%h b=%h, required 0abcd/04321", mop_a, mop_b);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [16:0] exp_a [5];
        logic [16:0] exp_b [5];
        logic [32:0] exp;
        exp_a = '{17'h00002, 17'h00002, 17'h00001, 17'h00001, 17'h0};
        exp_b = '{17'h00004, 17'h00003, 17'h00004, 17'h00003, 17'h0};
        issue(c_OP_MUL, 32'h0001_0002, 32'h0003_0004, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== (k >= 1 && k <= 4) || valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL mul_timing cyc%0d: busy=%b valid=%b, required busy=%b valid=%b",
                         k, busy, valid, (k >= 1 && k <= 4), (k == 4));
            end
            if (k < 5) begin
                n_checks++;
                if (mop_a !== exp_a[k] || mop_b !== exp_b[k]) begin
                    n_fail++;
                    $display("FAIL mul_operands cyc%0d: a=%h b=%h, required %h/%h",
                             k, mop_a, mop_b, exp_a[k], exp_b[k]);
                end
            end
            if (k == 4) begin
                exp = sb_q.pop_front();
                n_checks++;
                if ({ov, result} !== exp || exp !== {1'b0, 32'h000A_0008}) begin
                    n_fail++;
                    $display("FAIL mul_result: ov=%b result=%h, required ov=0 result=000a0008",
                             ov, result);
                end
            end
            @(posedge clk); #1;
            if (k == 4) en = 1'b0;
        end
    endtask

    task automatic test_kmmac_kmmsb();
        logic [1:0]  t_op [4];
        logic [31:0] t_a  [4];
        logic [31:0] t_b  [4];
        logic [31:0] t_c  [4];
        logic [32:0] exp;
        bit got;
        int lat;
        t_op = '{c_OP_KMMAC, c_OP_KMMSB, c_OP_KMMSB, c_OP_KMMAC};
        t_a  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        t_b  = '{32'h8000_0000, 32'h0000_0002, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        t_c  = '{32'h4000_0000, 32'h0000_0005, 32'h8000_0000, 32'h8000_0000};
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_c[i]);
            wait_valid(got, lat);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL kmm_timeout #%0d: no valid_o, required one", i);
                void'(sb_q.pop_front());
            end else begin
                exp = sb_q.pop_front();
                if ({ov, result} !== exp || lat != 4) begin
                    n_fail++;
                    $display("FAIL kmm_result #%0d: ov=%b result=%h lat=%0d, required ov=%b result=%h lat=4",
                             i, ov, result, lat, exp[32], exp[31:0]);
                end
            end
            @(posedge clk); #1;
            en = 1'b0;
        end
        // Anchor the table against the hand-derived values.
        n_checks++;
        if (model(c_OP_KMMAC, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000) !== {1'b1, 32'h7FFF_FFFF}
            || model(c_OP_KMMSB, 32'hFFFF_FFFF, 32'h2, 32'h5) !== {1'b0, 32'h6}) begin
            n_fail++;
            $display("FAIL kmm_model_anchor: model disagrees with 7fffffff/ov1 and 6/ov0");
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        bit got;
        int lat;
        issue(c_OP_MSUBR32, 32'd3, 32'd4, 32'd10);
        wait_valid(got, lat);
        n_checks++;
        if (!got || lat != 4 || {ov, result} !== {1'b0, 32'hFFFF_FFFE}) begin
            n_fail++;
            $display("FAIL msubr32: got=%b lat=%0d ov=%b result=%h, required lat=4 ov=0 result=fffffffe",
                     got, lat, ov, result);
        end
        void'(sb_q.pop_front());
        // en stays high into the IDLE cycle after FIN: the next op starts there.
        @(posedge clk); #1;
        issue(c_OP_MUL, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'h0);
        wait_valid(got, lat);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL b2b_timeout: no valid_o, required one");
            void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            if ({ov, result} !== exp || lat != 4) begin
                n_fail++;
                $display("FAIL b2b_mul: ov=%b result=%h lat=%0d, required ov=%b result=%h lat=4",
                         ov, result, lat, exp[32], exp[31:0]);
            end
        end
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic test_flush();
        logic [32:0] exp;
        bit got;
        int lat;
        bit seen;
        op = c_OP_KMMAC; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; c = 32'h1; en = 1'b1;
        @(posedge clk); #1;          // cycle 1: PP1
        @(posedge clk); #1;          // cycle 2: PP2
        flush = 1'b1;
        @(negedge clk);
        seen = valid;
        @(posedge clk); #1;
        flush = 1'b0; en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: busy=%b, required 0", busy);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            seen = seen | valid;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_valid: valid_o=1 seen, required 0");
        end
        @(posedge clk); #1;
        issue(c_OP_KMMAC, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1111_1111);
        wait_valid(got, lat);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL flush_next_timeout: no valid_o, required one");
            void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            if ({ov, result} !== exp || lat != 4) begin
                n_fail++;
                $display("FAIL flush_next_kmmac: ov=%b result=%h lat=%0d, required ov=%b result=%h lat=4",
                         ov, result, lat, exp[32], exp[31:0]);
            end
        end
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic test_flush_fin();
        bit seen;
        op = c_OP_MUL; a = 32'h5; b = 32'h7; c = 32'h0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;                // cycle 4: FIN
        @(negedge clk);
        seen = valid;
        @(posedge clk); #1;
        flush = 1'b0; en = 1'b0;
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_fin: valid_o=1, required 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [32:0] exp;
        bit got;
        int lat;
        op = c_OP_MUL; a = 32'h0001_0002; b = 32'h0003_0004; c = 32'h0; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1 || mop_a !== 17'h00001 || mop_b !== 17'h00003) begin
            n_fail++;
            $display("FAIL pp3_state: busy=%b a=%h b=%h, required 1/00001/00003", busy, mop_a, mop_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, valid, ov, result} !== 35'h0 || mop_a !== 17'h00002 || mop_b !== 17'h00004) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b valid=%b ov=%b result=%h a=%h b=%h, required zeros and 00002/00004",
                     busy, valid, ov, result, mop_a, mop_b);
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(c_OP_MUL, 32'h0001_0002, 32'h0003_0004, 32'h0);
        wait_valid(got, lat);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL post_reset_timeout: no valid_o, required one");
            void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            if ({ov, result} !== exp || result !== 32'h000A_0008 || lat != 4) begin
                n_fail++;
                $display("FAIL post_reset_mul: ov=%b result=%h lat=%0d, required ov=0 result=000a0008 lat=4",
                         ov, result, lat);
            end
        end
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic test_random_ops();
        logic [31:0] edges [5];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rc;
        logic [32:0] exp;
        bit got;
        int lat;
        edges = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_FFFF};
        for (int i = 0; i < 16; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            rc = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            issue(2'(i % 4), ra, rb, rc);
            wait_valid(got, lat);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL rand_timeout #%0d: no valid_o, required one", i);
                void'(sb_q.pop_front());
            end else begin
                exp = sb_q.pop_front();
                if ({ov, result} !== exp || lat != 4) begin
                    n_fail++;
                    $display("FAIL rand_op #%0d op=%0d a=%h b=%h c=%h: ov=%b result=%h lat=%0d, required ov=%b result=%h lat=4",
                             i, op, ra, rb, rc, ov, result, lat, exp[32], exp[31:0]);
                end
            end
            @(posedge clk); #1;
            if (i % 3 == 2) en = 1'b0;   // mix idle gaps with back-to-back issue
            if (i % 3 == 2) begin
                @(posedge clk); #1;
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_kmmac_kmmsb();
        test_back_to_back();
        test_flush();
        test_flush_fin();
        test_async_reset();
        test_random_ops();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
